// File: rtl/serial_pkg.sv
// Shared encodings and line levels for the serial transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick is high on the last cycle of each bit period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear restarts the period at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // With one clock per bit the counter stays at zero and tick is always high.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Every output is a flop, so the line never glitches.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int            BW   = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    state_t            state, state_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              tx_n, ready_n, busy_n, done_n;
    logic              tick;

    // The timer is held cleared while idle, so the accept edge starts a fresh period.
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= IDLE_LVL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            tx_ready <= ready_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output logic; each bit advances only on a timer tick.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ready_n   = tx_ready;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_n = tx_data;
                    state_n = START;
                    tx_n    = START_LVL;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST) begin
                        state_n = STOP;
                        tx_n    = STOP_LVL;
                    end else begin
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    tx_n    = IDLE_LVL;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = IDLE_LVL;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit) checked every cycle
// against a frame-position model of the expected line.
module tb_serial_tx;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          v [2];
    logic [W-1:0]  d [2];
    logic          tx_w [2], rdy_w [2], busy_w [2], done_w [2];

    int n_chk = 0, n_err = 0;
    int cyc_n = 0;

    // Model: position within frame (-1 = idle), latched word, expected done.
    int            pos [2];
    logic [W-1:0]  wd [2];
    logic          md [2];
    logic          acc [2];
    int            acc_at [2];
    int            dq0 [$];
    int            dq1 [$];

    always #5 clk = ~clk;

    serial_tx #(.CLKS_PER_BIT(4), .DATA_W(W)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    serial_tx #(.CLKS_PER_BIT(1), .DATA_W(W)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cpb(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int flen(input int i);
        return (W + 2) * cpb(i);
    endfunction

    // Frame bit j: 0 = start, 1..W = data LSB first, W+1 = stop.
    function automatic logic exp_tx(input int i);
        int j;
        if (pos[i] < 0) return 1'b1;
        j = pos[i] / cpb(i);
        if (j == 0) return 1'b0;
        if (j <= W) return wd[i][j-1];
        return 1'b1;
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            md[i]  = 1'b0;
            if (rst) begin
                pos[i] = -1;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] == flen(i)) begin
                    pos[i] = -1;
                    md[i]  = 1'b1;
                end
            end else if (v[i]) begin
                pos[i]    = 0;
                wd[i]     = d[i];
                acc[i]    = 1'b1;
                acc_at[i] = cyc_n;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx%0d@%0d", i, cyc_n),    tx_w[i],   exp_tx(i));
            chk($sformatf("rdy%0d@%0d", i, cyc_n),   rdy_w[i],  pos[i] < 0);
            chk($sformatf("busy%0d@%0d", i, cyc_n),  busy_w[i], pos[i] >= 0);
            chk($sformatf("done%0d@%0d", i, cyc_n),  done_w[i], md[i]);
        end
        if (done_w[0]) dq0.push_back(cyc_n);
        if (done_w[1]) dq1.push_back(cyc_n);
        @(negedge clk);
    endtask

    // Present a word and wait for its accept; hold keeps tx_valid high afterwards.
    task automatic send(input int i, input logic [W-1:0] x, input bit hold, output int waited);
        v[i] = 1'b1;
        d[i] = x;
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (!acc[i] && waited < 300);
        if (!acc[i]) chk("accept_timeout", 0, 1);
        if (!hold) v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (pos[i] >= 0 && n < 300) begin
            cyc();
            n++;
        end
        if (pos[i] >= 0) chk("idle_timeout", 0, 1);
        cyc();
    endtask

    initial begin
        int w, a1, a2;
        pos[0] = -1; pos[1] = -1;
        rst = 1'b1;
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = '0;   d[1] = '0;

        // Reset with no clock edge yet.
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx",   tx_w[i],   1'b1);
            chk("rst_rdy",  rdy_w[i],  1'b1);
            chk("rst_busy", busy_w[i], 1'b0);
            chk("rst_done", done_w[i], 1'b0);
        end
        v[0] = 1'b1;             // valid during reset must not be accepted
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        v[0] = 1'b0;
        cyc();

        // Single frame A5.
        dq0.delete();
        send(0, 8'hA5, 0, w);
        wait_idle(0);
        chk("a5_ndone", dq0.size(), 1);
        if (dq0.size() > 0) chk("a5_len", dq0[0] - acc_at[0], 40);

        // Back-to-back 00 then FF with valid held.
        dq0.delete();
        send(0, 8'h00, 1, w);
        a1 = acc_at[0];
        send(0, 8'hFF, 0, w);
        a2 = acc_at[0];
        chk("b2b_gap", a2 - a1, 41);
        wait_idle(0);
        chk("b2b_ndone", dq0.size(), 2);
        if (dq0.size() == 2) chk("b2b_dgap", dq0[1] - dq0[0], 41);

        // Valid with new data while busy.
        send(0, 8'h3C, 1, w);
        a1 = acc_at[0];
        repeat (15) cyc();
        d[0] = 8'hC3;
        repeat (10) cyc();
        send(0, 8'hC3, 0, w);
        chk("busy_ign_gap", acc_at[0] - a1, 41);
        wait_idle(0);

        // Reset during data bit 3 of 5A, between clock edges.
        dq0.delete();
        send(0, 8'h5A, 0, w);
        repeat (17) cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_tx",   tx_w[0],   1'b1);
        chk("arst_rdy",  rdy_w[0],  1'b1);
        chk("arst_busy", busy_w[0], 1'b0);
        chk("arst_done", done_w[0], 1'b0);
        cyc();
        rst = 1'b0;
        send(0, 8'h81, 0, w);
        chk("arst_acc_lat", w, 1);
        wait_idle(0);
        chk("arst_ndone", dq0.size(), 1);

        // One clock per bit.
        dq1.delete();
        send(1, 8'h01, 0, w);
        wait_idle(1);
        chk("c1_ndone", dq1.size(), 1);
        if (dq1.size() > 0) chk("c1_len", dq1[0] - acc_at[1], 10);

        // Random traffic, data churn and occasional resets.
        repeat (1500) begin
            for (int i = 0; i < 2; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                d[i] = W'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter with asynchronous reset.
- Frames a DATA_W-bit word as: start bit (0), data bits LSB first, stop bit (1).
- Drives the single-bit serial line that our DFF_AS-style capture flops sample on the receiving side.
- Sits between a parallel producer (valid/ready handshake) and the serial pin.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; integer >= 1.
- DATA_W, 8, data bits per frame; integer >= 1.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_W  word to send; sampled only on the accept edge.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word; registered.
- tx  output  1  serial line; registered; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - tx=1, tx_ready=1, busy=0, done=0.
  - state=IDLE, bit counter=0, tick counter=0.
- States: IDLE, START, DATA, STOP.
- Accept: at the rising edge E0 where tx_valid && tx_ready, the block registers:
  - shift register <= tx_data;
  - state <= START, tx <= 0, tx_ready <= 0, busy <= 1;
  - tick counter <= 0.
- Tick counter: counts 0..CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles.
  - Width = max(1, clog2(CLKS_PER_BIT)).
  - CLKS_PER_BIT=1 is legal: one cycle per bit.
- Start bit: tx=0 from E0 until edge E0+C, where C = CLKS_PER_BIT.
- Data: bit i (LSB first) is driven from edge E0+(i+1)*C, for i = 0..DATA_W-1.
  - Bit counter counts 0..DATA_W-1; the shift register shifts right once per bit.
- Stop bit: tx=1 from edge E0+(DATA_W+1)*C, held for C cycles.
- End of frame, at edge E0+(DATA_W+2)*C:
  - state <= IDLE, tx_ready <= 1, busy <= 0;
  - done <= 1 for exactly one cycle.
- Total frame length = (DATA_W+2)*C cycles.
- Back-to-back frames:
  - The earliest next accept is the edge after done is high, so the line stays high for at least one extra cycle between frames.
  - No frames are dropped while the producer holds tx_valid.
- tx_valid while busy: ignored, with no effect on the current frame. The word must still be present when tx_ready returns to 1.
- tx_data changes mid-frame: no effect, because the word is latched at accept.
- Reset mid-frame:
  - tx goes to 1 asynchronously and the frame is abandoned;
  - done is not pulsed;
  - the first accept is possible on the first edge after rst deasserts.
- tx_valid asserted during reset: not accepted until after rst deasserts.
- Glitch-free: all outputs come straight from flops, with no combinational path from input to output.

Decomposition:
- Shared package/include `serial_pkg`:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - line idle level IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- One natural sub-module, `bit_timer`:
  - parameterised by CLKS_PER_BIT;
  - ports clk, rst, clear, tick;
  - tick pulses on the last cycle of each bit period.
- The FSM and shift register stay in serial_tx.

Test Plan:
1. Reset check: rst=1 with no clock edges -> tx=1, tx_ready=1, busy=0, done=0 immediately. Also pulse rst between clk edges and confirm the asynchronous response.
2. Single frame, C=4, DATA_W=8, tx_data=8'hA5 accepted at E0:
   - tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1;
   - done=1 exactly at E0+40;
   - tx_ready=0 from E0 to E0+40.
3. Back-to-back, tx_valid held high with 8'h00 then 8'hFF:
   - second accept at E0+41;
   - line reads 0,0x8,1 then 1 (gap), then 0,1x8,1;
   - two done pulses, 41 cycles apart.
4. Busy interference: during the 8'h3C frame, drive tx_valid=1 with tx_data=8'hC3 mid-frame -> serial output is still 3C LSB-first (0,0,1,1,1,1,0,0), and C3 is sent only after tx_ready returns.
5. Reset mid-frame: assert rst during data bit 3 of 8'h5A -> tx=1 at once and no done pulse. After release, sending 8'h81 yields a clean frame 0,1,0,0,0,0,0,0,1,1.
6. Edge case C=1, DATA_W=8, tx_data=8'h01 -> frame lasts 10 cycles with tx=0,1,0,0,0,0,0,0,0,1, and done at E0+10.
